pwm_multichannel_gen: RTL and testbench

// Parametrised successor to the single-channel PWM generator. Drives NUM_CH independent PWM outputs

---
 rtl/pwm_multichannel_gen.sv | 135 +++++++++++++
 tb/tb_pwm_multichannel_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel_gen.sv
// Multi-channel PWM generator: one shared period counter drives NUM_CH outputs.
// Duty writes land in per-channel shadow registers and reach the outputs only at a period boundary.
module pwm_multichannel_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 20,
  parameter int PERIOD = 1000000,
  parameter int STEP   = 100000,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic              val_en,
  input  logic [CNT_W:0]    duty_val,
  input  logic              increase_duty,
  input  logic              decrease_duty,
  input  logic              center_mode,
  output logic [NUM_CH-1:0] PWM_OUT,
  output logic              period_tick,
  output logic [CNT_W:0]    duty_rd
);

  localparam int DW = CNT_W + 1;
  localparam int AW = CNT_W + 2;
  localparam logic [AW-1:0]    PERIOD_A = AW'(PERIOD);
  localparam logic [AW-1:0]    STEP_A   = AW'(STEP);
  localparam logic [DW-1:0]    PERIOD_D = DW'(PERIOD);
  localparam logic [DW-1:0]    HALF_D   = DW'(PERIOD / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     shadow_q [NUM_CH];
  logic [DW-1:0]     shadow_d [NUM_CH];
  logic [DW-1:0]     active_q [NUM_CH];
  logic [DW-1:0]     active_d [NUM_CH];
  logic              mode_q, mode_d;
  logic              inc_prev_q, dec_prev_q;
  logic [NUM_CH-1:0] pwm_q, pwm_d;

  logic              tick;
  logic              inc_edge, dec_edge;
  logic [AW-1:0]     inc_sum [NUM_CH];
  logic [AW-1:0]     lo_a    [NUM_CH];
  logic [AW-1:0]     hi_a    [NUM_CH];
  logic [AW-1:0]     act_a   [NUM_CH];
  logic [AW-1:0]     cnt_a;

  assign tick     = (cnt_q == CNT_LAST);
  assign inc_edge = increase_duty & ~inc_prev_q;
  assign dec_edge = decrease_duty & ~dec_prev_q;
  assign cnt_a    = {2'b00, cnt_q};

  // Shadow update for the selected channel; sums are one bit wider so clamping sees the overflow.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      inc_sum[i]  = {1'b0, shadow_q[i]} + STEP_A;
      if (SEL_W'(i) == ch_sel) begin
        if (val_en) begin
          shadow_d[i] = (duty_val > PERIOD_D) ? PERIOD_D : duty_val;
        end else if (inc_edge && dec_edge) begin
          shadow_d[i] = shadow_q[i];
        end else if (inc_edge) begin
          shadow_d[i] = (inc_sum[i] > PERIOD_A) ? PERIOD_D : inc_sum[i][DW-1:0];
        end else if (dec_edge) begin
          if ({1'b0, shadow_q[i]} < STEP_A) begin
            shadow_d[i] = '0;
          end else begin
            shadow_d[i] = DW'({1'b0, shadow_q[i]} - STEP_A);
          end
        end
      end
    end
  end

  // Counter and boundary transfer; a write in the last cycle is carried into the next period.
  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    mode_d = tick ? center_mode : mode_q;
    for (int i = 0; i < NUM_CH; i++) begin
      active_d[i] = tick ? shadow_d[i] : active_q[i];
    end
  end

  // Center mode places the high window symmetrically; high time is active cycles in both modes.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      act_a[i] = {1'b0, active_q[i]};
      lo_a[i]  = (PERIOD_A - act_a[i]) >> 1;
      hi_a[i]  = lo_a[i] + act_a[i];
      if (mode_q) begin
        pwm_d[i] = (cnt_a >= lo_a[i]) && (cnt_a < hi_a[i]);
      end else begin
        pwm_d[i] = (cnt_a < act_a[i]);
      end
    end
  end

  always_comb begin
    duty_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (SEL_W'(i) == ch_sel) begin
        duty_rd = active_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      inc_prev_q <= 1'b1;
      dec_prev_q <= 1'b1;
      pwm_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= HALF_D;
        active_q[i] <= HALF_D;
      end
    end else begin
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      inc_prev_q <= increase_duty;
      dec_prev_q <= decrease_duty;
      pwm_q      <= pwm_d;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign PWM_OUT     = pwm_q;
  assign period_tick = tick;

endmodule

// File: tb/tb_pwm_multichannel_gen.sv
// Directed bench for pwm_multichannel_gen with NUM_CH=2, CNT_W=4, PERIOD=10, STEP=2.
// Patterns are 10-bit masks where bit k is the output level while the counter read k.
module tb_pwm_multichannel_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] ch_sel;
  logic       val_en;
  logic [4:0] duty_val;
  logic       increase_duty;
  logic       decrease_duty;
  logic       center_mode;
  logic [1:0] PWM_OUT;
  logic       period_tick;
  logic [4:0] duty_rd;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [9:0] exp_q[$];

  pwm_multichannel_gen #(
    .NUM_CH(2), .CNT_W(4), .PERIOD(10), .STEP(2)
  ) dut (
    .clk(clk), .rst(rst), .ch_sel(ch_sel), .val_en(val_en), .duty_val(duty_val),
    .increase_duty(increase_duty), .decrease_duty(decrease_duty), .center_mode(center_mode),
    .PWM_OUT(PWM_OUT), .period_tick(period_tick), .duty_rd(duty_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock; exp_cnt is the bench's own model of the period counter after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    exp_cnt = (exp_cnt == 9) ? 0 : exp_cnt + 1;
    check("period_tick", 32'(period_tick), 32'(exp_cnt == 9));
  endtask

  task automatic wait_cnt(input int k);
    int guard = 0;
    while (exp_cnt != k && guard < 20) begin
      step();
      guard++;
    end
  endtask

  // Record one full period of both channels; val_en is pulsed in the cycle the counter reads wr_at.
  task automatic measure(input string tag, input int wr_at, input logic [9:0] e0, input logic [9:0] e1);
    logic [9:0] p0, p1;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    wait_cnt(0);
    for (int k = 0; k < 10; k++) begin
      val_en = (k == wr_at);
      step();
      p0[k] = PWM_OUT[0];
      p1[k] = PWM_OUT[1];
    end
    val_en = 1'b0;
    check({tag, "_ch0"}, 32'(p0), 32'(exp_q.pop_front()));
    check({tag, "_ch1"}, 32'(p1), 32'(exp_q.pop_front()));
  endtask

  task automatic pulse_inc();
    increase_duty = 1'b1; step();
    increase_duty = 1'b0; step();
  endtask

  task automatic pulse_dec();
    decrease_duty = 1'b1; step();
    decrease_duty = 1'b0; step();
  endtask

  initial begin
    rst = 1'b1; ch_sel = 1'b0; val_en = 1'b0; duty_val = '0;
    increase_duty = 1'b0; decrease_duty = 1'b0; center_mode = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pwm", 32'(PWM_OUT), 32'd0);
    check("rst_tick", 32'(period_tick), 32'd0);
    check("rst_duty0", 32'(duty_rd), 32'd5);
    ch_sel = 1'b1; #1;
    check("rst_duty1", 32'(duty_rd), 32'd5);
    ch_sel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;

    // 1: free run at 50%
    measure("t1_a", -1, 10'h01F, 10'h01F);
    measure("t1_b", -1, 10'h01F, 10'h01F);

    // 2: held increase on ch0 steps once, takes effect next period, then clamps at PERIOD
    ch_sel = 1'b0;
    increase_duty = 1'b1;
    measure("t2_cur", -1, 10'h01F, 10'h01F);
    measure("t2_n1", -1, 10'h07F, 10'h01F);
    measure("t2_n2", -1, 10'h07F, 10'h01F);
    increase_duty = 1'b0;
    check("t2_duty7", 32'(duty_rd), 32'd7);
    pulse_inc(); pulse_inc(); pulse_inc();
    check("t2_mid_hold", 32'(duty_rd), 32'd7);
    measure("t2_full_a", -1, 10'h3FF, 10'h01F);
    measure("t2_full_b", -1, 10'h3FF, 10'h01F);
    check("t2_duty10", 32'(duty_rd), 32'd10);

    // 3: direct load on ch1 mid-period, clamp of oversize value, write in the boundary cycle
    ch_sel = 1'b1;
    duty_val = 5'd3;
    measure("t3_cur", 2, 10'h3FF, 10'h01F);
    measure("t3_d3", -1, 10'h3FF, 10'h007);
    check("t3_duty3", 32'(duty_rd), 32'd3);
    duty_val = 5'd15;
    measure("t3_bnd", 9, 10'h3FF, 10'h007);
    check("t3_clamp", 32'(duty_rd), 32'd10);
    measure("t3_full", -1, 10'h3FF, 10'h3FF);
    duty_val = 5'd3;
    measure("t3_reload", 0, 10'h3FF, 10'h3FF);
    check("t3_duty3b", 32'(duty_rd), 32'd3);

    // 4: decrements saturate at 0; simultaneous edges leave duty unchanged
    pulse_dec(); pulse_dec(); pulse_dec();
    check("t4_mid_hold", 32'(duty_rd), 32'd3);
    wait_cnt(0);
    check("t4_duty0", 32'(duty_rd), 32'd0);
    measure("t4_low", -1, 10'h3FF, 10'h000);
    increase_duty = 1'b1; decrease_duty = 1'b1; step();
    increase_duty = 1'b0; decrease_duty = 1'b0; step();
    wait_cnt(0);
    check("t4_both", 32'(duty_rd), 32'd0);

    // 5: center-aligned output, mode latched at the boundary
    center_mode = 1'b1;
    duty_val = 5'd4;
    measure("t5_pre", 0, 10'h3FF, 10'h000);
    measure("t5_c4", -1, 10'h3FF, 10'h078);
    duty_val = 5'd5;
    measure("t5_c4b", 0, 10'h3FF, 10'h078);
    measure("t5_c5", -1, 10'h3FF, 10'h07C);

    // 6: asynchronous reset mid-period
    ch_sel = 1'b0;
    wait_cnt(6);
    check("t6_pre", 32'(PWM_OUT), 32'h3);
    #1 rst = 1'b1;
    #1;
    check("t6_async_pwm", 32'(PWM_OUT), 32'd0);
    check("t6_async_duty", 32'(duty_rd), 32'd5);
    repeat (3) @(posedge clk);
    #1;
    check("t6_hold_pwm", 32'(PWM_OUT), 32'd0);
    check("t6_hold_tick", 32'(period_tick), 32'd0);
    rst = 1'b0;
    exp_cnt = 0;
    measure("t6_edge", -1, 10'h01F, 10'h01F);
    measure("t6_center", -1, 10'h07C, 10'h07C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
